note_display_sched: RTL and testbench
=====================================

Name: note_display_sched

Overview:
- Shares one note_rom lookup among NUM_VOICES voices of the music player.
- A new note on any voice marks that voice pending. A round-robin scheduler then drives the voice's note into the ROM and captures the three returned character addresses.
- It writes letter, sharp/space and octave characters into the text display buffer through a valid/ready write port.
- It sits between the note players and the character display.

Parameters:
- NUM_VOICES, 3, number of voices sharing the ROM (1..4); voice v owns display row v.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- note_in  input  6*NUM_VOICES  current note per voice; voice v = bits [6v+5:6v].
- note_valid  input  NUM_VOICES  one-cycle strobe per voice: new note present on note_in.
- rom_note  output  6  note index driven to note_rom (registered).
- rom_num_addr  input  9  note_rom octave-number char address, combinational from rom_note.
- rom_letter_addr  input  9  note_rom letter char address.
- rom_symbol_addr  input  9  note_rom symbol char address.
- wr_valid  output  1  display write request.
- wr_ready  input  1  display accepts write when wr_valid & wr_ready at a rising edge.
- wr_row  output  2  display row = serviced voice index.
- wr_col  output  2  0 letter, 1 symbol, 2 number.
- wr_char  output  6  character code = selected address [8:3].
- busy  output  1  high in any state except IDLE.

Behaviour:
Reset:
- wr_valid=0, wr_row=0, wr_col=0, wr_char=0, rom_note=0, busy=0.
- All pending flags and latched notes cleared; round-robin pointer = NUM_VOICES-1, so voice 0 wins first.

Pending capture:
- note_valid[v] sampled at an edge sets pending[v] and latches note_in[v] into note_q[v].
- A later strobe before service overwrites note_q[v]. Only the newest note is displayed; no queueing.

FSM states: IDLE, LOOKUP, WR_LETTER, WR_SYMBOL, WR_NUMBER.
- IDLE, any pending:
  - Grant the first pending voice searching from pointer+1, wrapping modulo NUM_VOICES.
  - Set pointer = granted voice and rom_note = note_q[granted].
  - Clear pending[granted], unless note_valid[granted] is high that same edge; then pending stays set and note_q takes the new note.
  - Go to LOOKUP.
- LOOKUP, one cycle: capture the three ROM addresses into internal registers; go to WR_LETTER.
- WR_LETTER / WR_SYMBOL / WR_NUMBER:
  - wr_valid=1, wr_row=granted voice, wr_col=0/1/2.
  - wr_char = captured letter/symbol/number address [8:3].
  - Outputs held stable until the handshake; on handshake advance to the next state (WR_NUMBER -> IDLE).
  - wr_valid drops to 0 on entry to IDLE.
- Strobes arriving during LOOKUP/WR_* only set pending and never disturb the captured characters being written.

Latency:
- note_valid sampled at edge E0 -> LOOKUP after E1 -> wr_valid high after E2.
- With wr_ready=1, writes complete at E3, E4, E5; back in IDLE after E5.
- Minimum 5 cycles per voice update; back-to-back grants without idle cycles when more voices are pending.

Boundaries and reset:
- Unused voice indices (>= NUM_VOICES) are never granted.
- wr_ready low stalls indefinitely without losing pending strobes.
- Reset mid-write aborts immediately: wr_valid=0, partial row left as written, all pending lost.

Test Plan:
- Single note: voice 0 strobe, note 6'd14, wr_ready=1 -> writes (row0,col0,0x01), (row0,col1,0x23), (row0,col2,0x32); first wr_valid 3 cycles after strobe; busy low after 5th cycle.
- Rest and top note: voice 1 note 6'd0 -> chars 0x20,0x20,0x20 on row 1; voice 2 note 6'd63 -> 0x02,0x20,0x36 on row 2.
- Round robin: all three voices strobed same cycle -> service order 0,1,2. Strobe 0 and 2 again during voice-2 writes -> next order 0 then 2.
- Overwrite and collision:
  - voice 1 strobed 6'd4 then 6'd9 before grant -> only C (0x03) and F (0x06) path seen once, displaying 6'd9 chars.
  - Strobe coinciding with own grant -> voice re-serviced afterwards.
- Backpressure: wr_ready low 7 cycles during WR_SYMBOL -> wr_valid, wr_row, wr_col, wr_char stable; resumes correctly when ready rises.
- Async reset asserted mid-WR_SYMBOL, away from a clock edge -> wr_valid=0 and busy=0 immediately; after release with no strobes, no writes occur.

Source files
------------

// File: rtl/note_display_sched.sv
// note_display_sched: round-robin sharing of one note_rom among several voices,
// streaming letter / symbol / octave characters into the text display buffer.
module note_display_sched #(
    parameter int unsigned NUM_VOICES = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [6*NUM_VOICES-1:0]    note_in,
    input  logic [NUM_VOICES-1:0]      note_valid,
    output logic [5:0]                 rom_note,
    input  logic [8:0]                 rom_num_addr,
    input  logic [8:0]                 rom_letter_addr,
    input  logic [8:0]                 rom_symbol_addr,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [1:0]                 wr_row,
    output logic [1:0]                 wr_col,
    output logic [5:0]                 wr_char,
    output logic                       busy
);

    localparam int unsigned NW = 6;   // note index width
    localparam int unsigned CW = 6;   // character code width
    localparam int unsigned RW = 2;   // row / voice index width

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WR_LETTER,
        S_WR_SYMBOL,
        S_WR_NUMBER
    } state_t;

    state_t                          state_q, state_d;
    logic [NUM_VOICES-1:0]           pending_q, pending_d;
    logic [NUM_VOICES-1:0][NW-1:0]   note_q, note_d;
    logic [RW-1:0]                   ptr_q, ptr_d;
    logic [NW-1:0]                   rom_note_q, rom_note_d;
    logic [CW-1:0]                   sym_q, sym_d;
    logic [CW-1:0]                   num_q, num_d;
    logic                            wr_valid_q, wr_valid_d;
    logic [RW-1:0]                   wr_row_q, wr_row_d;
    logic [1:0]                      wr_col_q, wr_col_d;
    logic [CW-1:0]                   wr_char_q, wr_char_d;
    logic                            busy_q, busy_d;

    logic                            grant_found;
    int unsigned                     grant_int;
    int unsigned                     cand;
    logic                            hs;

    // Low address bits select a pixel row inside a glyph and are not needed here.
    logic                            unused_addr_bits;
    assign unused_addr_bits = ^{rom_num_addr[2:0], rom_letter_addr[2:0], rom_symbol_addr[2:0]};

    // Round-robin search for the first pending voice after the last one granted.
    always_comb begin
        grant_found = 1'b0;
        grant_int   = 0;
        cand        = 0;
        for (int unsigned i = 1; i <= NUM_VOICES; i++) begin
            cand = (32'(ptr_q) + i) % NUM_VOICES;
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_int   = cand;
            end
        end
    end

    // Next-state, pending capture and registered output values.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | note_valid;
        note_d     = note_q;
        ptr_d      = ptr_q;
        rom_note_d = rom_note_q;
        sym_d      = sym_q;
        num_d      = num_q;
        wr_valid_d = wr_valid_q;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_char_d  = wr_char_q;
        hs         = wr_valid_q & wr_ready;

        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (note_valid[v]) begin
                note_d[v] = note_in[v*NW +: NW];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d              = S_LOOKUP;
                    ptr_d                = RW'(grant_int);
                    wr_row_d             = RW'(grant_int);
                    rom_note_d           = note_q[grant_int];
                    // A strobe landing on the grant edge keeps the voice pending.
                    pending_d[grant_int] = note_valid[grant_int];
                end
            end
            S_LOOKUP: begin
                // Letter goes straight to the output; symbol and number wait their turn.
                sym_d      = rom_symbol_addr[8:3];
                num_d      = rom_num_addr[8:3];
                wr_char_d  = rom_letter_addr[8:3];
                wr_col_d   = 2'd0;
                wr_valid_d = 1'b1;
                state_d    = S_WR_LETTER;
            end
            S_WR_LETTER: begin
                if (hs) begin
                    wr_col_d  = 2'd1;
                    wr_char_d = sym_q;
                    state_d   = S_WR_SYMBOL;
                end
            end
            S_WR_SYMBOL: begin
                if (hs) begin
                    wr_col_d  = 2'd2;
                    wr_char_d = num_q;
                    state_d   = S_WR_NUMBER;
                end
            end
            S_WR_NUMBER: begin
                if (hs) begin
                    wr_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                wr_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            note_q     <= '0;
            ptr_q      <= RW'(NUM_VOICES - 1);
            rom_note_q <= '0;
            sym_q      <= '0;
            num_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_char_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            note_q     <= note_d;
            ptr_q      <= ptr_d;
            rom_note_q <= rom_note_d;
            sym_q      <= sym_d;
            num_q      <= num_d;
            wr_valid_q <= wr_valid_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            wr_char_q  <= wr_char_d;
            busy_q     <= busy_d;
        end
    end

    assign rom_note = rom_note_q;
    assign wr_valid = wr_valid_q;
    assign wr_row   = wr_row_q;
    assign wr_col   = wr_col_q;
    assign wr_char  = wr_char_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_note_display_sched.sv
// Bench for note_display_sched: note_rom stand-in, transaction-level scheduler
// model, directed scenarios followed by randomized traffic.
module tb_note_display_sched;

    localparam int NV = 3;

    logic              clk;
    logic              reset;
    logic [6*NV-1:0]   note_in;
    logic [NV-1:0]     note_valid;
    logic [5:0]        rom_note;
    logic [8:0]        rom_num_addr;
    logic [8:0]        rom_letter_addr;
    logic [8:0]        rom_symbol_addr;
    logic              wr_valid;
    logic              wr_ready;
    logic [1:0]        wr_row;
    logic [1:0]        wr_col;
    logic [5:0]        wr_char;
    logic              busy;

    note_display_sched #(.NUM_VOICES(NV)) dut (
        .clk             (clk),
        .reset           (reset),
        .note_in         (note_in),
        .note_valid      (note_valid),
        .rom_note        (rom_note),
        .rom_num_addr    (rom_num_addr),
        .rom_letter_addr (rom_letter_addr),
        .rom_symbol_addr (rom_symbol_addr),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_row          (wr_row),
        .wr_col          (wr_col),
        .wr_char         (wr_char),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Character for a note: sel 0 letter, 1 sharp/space, 2 octave digit. Note 0 is a rest.
    function automatic logic [5:0] note_char(input logic [5:0] n, input int sel);
        int idx;
        int oct;
        logic [5:0] l;
        logic sharp;
        if (n == 6'd0) return 6'h20;
        idx = (int'(n) + 8) % 12;
        oct = (int'(n) + 8) / 12 + 1;
        case (idx)
            0, 1:    l = 6'h03;  // C
            2, 3:    l = 6'h04;  // D
            4:       l = 6'h05;  // E
            5, 6:    l = 6'h06;  // F
            7, 8:    l = 6'h07;  // G
            9, 10:   l = 6'h01;  // A
            default: l = 6'h02;  // B
        endcase
        sharp = (idx == 1 || idx == 3 || idx == 6 || idx == 8 || idx == 10);
        if (sel == 0) return l;
        if (sel == 1) return sharp ? 6'h23 : 6'h20;
        return 6'(48 + oct);
    endfunction

    // note_rom stand-in; low address bits carry junk the DUT must ignore.
    always_comb begin
        rom_letter_addr = {note_char(rom_note, 0), rom_note[2:0]};
        rom_symbol_addr = {note_char(rom_note, 1), ~rom_note[2:0]};
        rom_num_addr    = {note_char(rom_note, 2), rom_note[5:3]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Scheduler model: pending set, newest notes, last grant, current service.
    bit          m_pend[NV];
    logic [5:0]  m_note[NV];
    int          m_last;
    bit          m_active;
    int          m_voice;
    int          m_phase;      // -1 lookup, 0..2 writing that column
    logic [5:0]  m_chars[3];
    logic [5:0]  m_rom;
    logic [9:0]  wlog[$];

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_pend[v] = 1'b0;
            m_note[v] = 6'd0;
        end
        m_last   = NV - 1;
        m_active = 1'b0;
        m_voice  = 0;
        m_phase  = -1;
        m_rom    = 6'd0;
    endtask

    task automatic model_edge(input logic [NV-1:0] nv, input logic [6*NV-1:0] ni, input logic rdy);
        bit found;
        int g;
        found = 1'b0;
        if (!m_active) begin
            for (int i = 1; i <= NV; i++) begin
                g = (m_last + i) % NV;
                if (!found && m_pend[g]) begin
                    found     = 1'b1;
                    m_active  = 1'b1;
                    m_voice   = g;
                    m_phase   = -1;
                    m_last    = g;
                    m_rom     = m_note[g];
                    m_pend[g] = 1'b0;
                    for (int s = 0; s < 3; s++) m_chars[s] = note_char(m_note[g], s);
                end
            end
        end else if (m_phase < 0) begin
            m_phase = 0;
        end else if (rdy) begin
            m_phase++;
            if (m_phase == 3) m_active = 1'b0;
        end
        for (int v = 0; v < NV; v++) begin
            if (nv[v]) begin
                m_pend[v] = 1'b1;
                m_note[v] = ni[6*v +: 6];
            end
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = m_active && (m_phase >= 0);
        chk("busy", 32'(busy), 32'(m_active));
        chk("wr_valid", 32'(wr_valid), 32'(ev));
        chk("rom_note", 32'(rom_note), 32'(m_rom));
        if (ev) begin
            chk("wr_row", 32'(wr_row), 32'(m_voice));
            chk("wr_col", 32'(wr_col), 32'(m_phase));
            chk("wr_char", 32'(wr_char), 32'(m_chars[m_phase]));
        end
    endtask

    // One clock: check at negedge, drive inputs, advance model, wait to next negedge.
    task automatic step(input logic [NV-1:0] nv, input logic [6*NV-1:0] ni, input logic rdy);
        check_outputs();
        note_valid = nv;
        note_in    = ni;
        wr_ready   = rdy;
        if (wr_valid && rdy) wlog.push_back({wr_row, wr_col, wr_char});
        model_edge(nv, ni, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b1);
    endtask

    function automatic logic [6*NV-1:0] pk(input logic [5:0] n0, input logic [5:0] n1, input logic [5:0] n2);
        return {n2, n1, n0};
    endfunction

    // Step with ready high until the model reaches the symbol write; bounded.
    task automatic run_to_symbol(input string tag);
        int k;
        k = 0;
        while (!(m_active && m_phase == 1) && k < 20) begin
            step('0, '0, 1'b1);
            k++;
        end
        chk(tag, 32'(m_active && m_phase == 1 && k < 20), 32'd1);
    endtask

    logic [5:0] exp3[3];
    logic [9:0] snap;
    int         cnt;
    int         exp_rows[5];

    initial begin
        reset      = 1'b1;
        note_valid = '0;
        note_in    = '0;
        wr_ready   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_row", 32'(wr_row), 32'd0);
        chk("rst_wr_col", 32'(wr_col), 32'd0);
        chk("rst_wr_char", 32'(wr_char), 32'd0);
        chk("rst_rom_note", 32'(rom_note), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Single note on voice 0: A#2.
        wlog.delete();
        step(3'b001, pk(6'd14, 6'd0, 6'd0), 1'b1);
        idle(7);
        chk("single_cnt", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            chk("single_w0", 32'(wlog[0]), 32'({2'd0, 2'd0, 6'h01}));
            chk("single_w1", 32'(wlog[1]), 32'({2'd0, 2'd1, 6'h23}));
            chk("single_w2", 32'(wlog[2]), 32'({2'd0, 2'd2, 6'h32}));
        end

        // Rest on voice 1, top note on voice 2.
        wlog.delete();
        step(3'b010, pk(6'd0, 6'd0, 6'd0), 1'b1);
        idle(6);
        step(3'b100, pk(6'd0, 6'd0, 6'd63), 1'b1);
        idle(6);
        chk("edge_cnt", 32'(wlog.size()), 32'd6);
        if (wlog.size() == 6) begin
            chk("rest_w0", 32'(wlog[0]), 32'({2'd1, 2'd0, 6'h20}));
            chk("rest_w2", 32'(wlog[2]), 32'({2'd1, 2'd2, 6'h20}));
            chk("top_w0", 32'(wlog[3]), 32'({2'd2, 2'd0, 6'h02}));
            chk("top_w1", 32'(wlog[4]), 32'({2'd2, 2'd1, 6'h20}));
            chk("top_w2", 32'(wlog[5]), 32'({2'd2, 2'd2, 6'h36}));
        end

        // Round robin: all three at once, then 0 and 2 again during voice 2 service.
        wlog.delete();
        step(3'b111, pk(6'd5, 6'd20, 6'd40), 1'b1);
        idle(12);
        step(3'b101, pk(6'd30, 6'd0, 6'd50), 1'b1);
        idle(16);
        exp_rows = '{0, 1, 2, 0, 2};
        chk("rr_cnt", 32'(wlog.size()), 32'd15);
        if (wlog.size() == 15)
            for (int i = 0; i < 5; i++) chk("rr_order", 32'(wlog[3*i][9:8]), 32'(exp_rows[i]));

        // Overwrite: voice 1 strobed twice while voice 0 is being serviced.
        wlog.delete();
        step(3'b001, pk(6'd20, 6'd0, 6'd0), 1'b1);
        step(3'b010, pk(6'd0, 6'd4, 6'd0), 1'b1);
        step(3'b010, pk(6'd0, 6'd9, 6'd0), 1'b1);
        idle(12);
        exp3 = '{6'h06, 6'h20, 6'h32};
        cnt  = 0;
        foreach (wlog[i]) begin
            if (wlog[i][9:8] == 2'd1) begin
                if (cnt < 3) chk("ovw_char", 32'(wlog[i][5:0]), 32'(exp3[cnt]));
                cnt++;
            end
        end
        chk("ovw_cnt", 32'(cnt), 32'd3);

        // Collision: strobe on the grant edge re-services the voice.
        wlog.delete();
        step(3'b010, pk(6'd0, 6'd33, 6'd0), 1'b1);
        step(3'b010, pk(6'd0, 6'd34, 6'd0), 1'b1);
        idle(12);
        chk("coll_cnt", 32'(wlog.size()), 32'd6);

        // Backpressure: ready low for 7 cycles during the symbol write.
        step(3'b100, pk(6'd0, 6'd0, 6'd50), 1'b1);
        run_to_symbol("bp_reach");
        snap = {wr_row, wr_col, wr_char};
        for (int i = 0; i < 7; i++) begin
            chk("bp_valid", 32'(wr_valid), 32'd1);
            chk("bp_hold", 32'({wr_row, wr_col, wr_char}), 32'(snap));
            step('0, '0, 1'b0);
        end
        idle(6);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            logic [NV-1:0]   rnv;
            logic [6*NV-1:0] rni;
            for (int v = 0; v < NV; v++) rnv[v] = ($urandom_range(0, 9) == 0);
            rni = 18'($urandom);
            step(rnv, rni, ($urandom_range(0, 3) != 0));
        end
        idle(20);

        // Asynchronous reset in the middle of the symbol write.
        step(3'b001, pk(6'd27, 6'd0, 6'd0), 1'b1);
        step(3'b110, pk(6'd0, 6'd11, 6'd12), 1'b1);
        run_to_symbol("rst_reach");
        note_valid = '0;
        wr_ready   = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_wr_valid", 32'(wr_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        wlog.delete();
        idle(12);
        chk("arst_no_writes", 32'(wlog.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
